// File: rtl/cmd_arbiter.sv
// cmd_arbiter: shares one engine command port between NUM_REQ sources with per-source holding slots
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   req_cmd    packed requester opcodes, requester i at [i*CMD_W +: CMD_W]
//   req_arg0   packed requester arguments, requester i at [i*ARG_W +: ARG_W]
//   req_valid  per-requester valid
//   req_ready  per-requester ready (slot empty)
//   cmd        opcode to the engine
//   cmd_arg0   argument to the engine
//   cmd_valid  command valid to the engine
//   cmd_ready  engine ready
//   grant      one-hot owner of the command on the port, 0 when idle
//   busy       any slot pending or command on the port
//   stall      sticky watchdog flag for an unresponsive engine
module cmd_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int CMD_W    = 3,
    parameter int ARG_W    = 32,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 1000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
    input  logic [NUM_REQ*ARG_W-1:0] req_arg0,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [CMD_W-1:0]         cmd,
    output logic [ARG_W-1:0]         cmd_arg0,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic                     stall
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t             state;
    logic [NUM_REQ-1:0] pend;
    logic [CMD_W-1:0]   slot_cmd [NUM_REQ];
    logic [ARG_W-1:0]   slot_arg [NUM_REQ];
    logic [IW-1:0]      last, owner, win, j;
    logic [WW-1:0]      wd;

    // Scan order: round-robin starts after the last owner, fixed priority starts at 0.
    function automatic int pick(int k, logic [IW-1:0] l);
        return (ARB_MODE != 0) ? k - 1 : (int'(l) + k) % NUM_REQ;
    endfunction

    assign req_ready = ~pend;
    assign busy      = |pend | cmd_valid;

    // Scanning from the far end lets the earliest candidate in scan order overwrite the rest.
    always_comb begin
        win = '0;
        j   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = IW'(pick(k, last));
            if (pend[j]) win = j;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pend      <= '0;
            cmd       <= '0;
            cmd_arg0  <= '0;
            cmd_valid <= 1'b0;
            grant     <= '0;
            last      <= IW'(NUM_REQ - 1);
            owner     <= '0;
            wd        <= '0;
            stall     <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_cmd[i] <= '0;
                slot_arg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && !pend[i]) begin
                    pend[i]     <= 1'b1;
                    slot_cmd[i] <= req_cmd[i*CMD_W +: CMD_W];
                    slot_arg[i] <= req_arg0[i*ARG_W +: ARG_W];
                end
            end
            case (state)
                IDLE: begin
                    if (|pend) begin
                        cmd       <= slot_cmd[win];
                        cmd_arg0  <= slot_arg[win];
                        cmd_valid <= 1'b1;
                        grant     <= NUM_REQ'(1) << win;
                        pend[win] <= 1'b0;
                        owner     <= win;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        grant     <= '0;
                        last      <= owner;
                        wd        <= '0;
                        state     <= IDLE;
                    end else begin
                        if (wd < WW'(TIMEOUT)) wd <= wd + 1'b1;
                        // Flag on the edge where the counter reaches TIMEOUT.
                        if (wd >= WW'(TIMEOUT - 1)) stall <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
